// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter that shares one synchronous RAM port
// between the core load/store path, the hardware stack unit and the debug
// port. One access is issued per cycle from registered command outputs.
// Read data is returned two cycles after the grant, with an owner tag.
module dmem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              stk_req,
  input  logic              dbg_req,
  input  logic              core_we,
  input  logic              stk_we,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [ADDR_W-1:0] stk_addr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [DATA_W-1:0] stk_wdata,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              core_gnt,
  output logic              stk_gnt,
  output logic              dbg_gnt,
  output logic              core_rvalid,
  output logic              stk_rvalid,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Requester indices; also the bit positions in the gnt/rvalid vectors.
  localparam logic [1:0] IDX_CORE = 2'd0;
  localparam logic [1:0] IDX_STK  = 2'd1;
  localparam logic [1:0] IDX_DBG  = 2'd2;

  logic [2:0]              req_vec;
  logic [2:0]              we_vec;
  logic [2:0][ADDR_W-1:0]  addr_vec;
  logic [2:0][DATA_W-1:0]  wdata_vec;

  assign req_vec   = {dbg_req, stk_req, core_req};
  assign we_vec    = {dbg_we, stk_we, core_we};
  assign addr_vec  = {dbg_addr, stk_addr, core_addr};
  assign wdata_vec = {dbg_wdata, stk_wdata, core_wdata};

  logic [1:0]        last_reg;   // last granted requester
  logic              sel_valid;
  logic [1:0]        sel_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_in_range;

  // Round-robin pick: search starts at the requester after the last grant.
  always_comb begin
    sel_valid = |req_vec;
    sel_idx   = IDX_CORE;
    case (last_reg)
      IDX_CORE: begin
        if (req_vec[IDX_STK])      sel_idx = IDX_STK;
        else if (req_vec[IDX_DBG]) sel_idx = IDX_DBG;
        else                       sel_idx = IDX_CORE;
      end
      IDX_STK: begin
        if (req_vec[IDX_DBG])       sel_idx = IDX_DBG;
        else if (req_vec[IDX_CORE]) sel_idx = IDX_CORE;
        else                        sel_idx = IDX_STK;
      end
      default: begin
        if (req_vec[IDX_CORE])     sel_idx = IDX_CORE;
        else if (req_vec[IDX_STK]) sel_idx = IDX_STK;
        else                       sel_idx = IDX_DBG;
      end
    endcase
    sel_we       = we_vec[sel_idx];
    sel_addr     = addr_vec[sel_idx];
    sel_wdata    = wdata_vec[sel_idx];
    sel_in_range = (32'(sel_addr) < MEM_DEPTH);
  end

  logic [2:0]        gnt_reg;
  logic              err_reg;
  logic              mem_en_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;

  // Issue stage: register the winner's command. Out-of-range accesses are
  // granted and flagged, but never enable the RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_reg       <= '0;
      err_reg       <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      last_reg      <= IDX_DBG;
    end else begin
      gnt_reg    <= '0;
      err_reg    <= 1'b0;
      mem_en_reg <= 1'b0;
      mem_we_reg <= 1'b0;
      if (sel_valid) begin
        gnt_reg[sel_idx] <= 1'b1;
        err_reg          <= ~sel_in_range;
        mem_en_reg       <= sel_in_range;
        mem_we_reg       <= sel_we & sel_in_range;
        mem_addr_reg     <= sel_addr;
        mem_wdata_reg    <= sel_wdata;
        last_reg         <= sel_idx;
      end
    end
  end

  // Two-entry owner tag pipeline. Stage 0 covers the issue cycle, stage 1
  // the cycle in which mem_rdata is valid. The oor flag forces rdata to 0.
  logic       t0_valid, t1_valid;
  logic       t0_oor, t1_oor;
  logic [1:0] t0_owner, t1_owner;

  // Track each read's owner until its data returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t0_valid <= 1'b0;
      t0_oor   <= 1'b0;
      t0_owner <= IDX_CORE;
      t1_valid <= 1'b0;
      t1_oor   <= 1'b0;
      t1_owner <= IDX_CORE;
    end else begin
      t0_valid <= sel_valid & ~sel_we;
      t0_oor   <= ~sel_in_range;
      t0_owner <= sel_idx;
      t1_valid <= t0_valid;
      t1_oor   <= t0_oor;
      t1_owner <= t0_owner;
    end
  end

  logic [2:0]        rvalid_reg;
  logic [DATA_W-1:0] rdata_reg;

  // Return stage: capture RAM data and pulse the owner's rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_reg <= '0;
      rdata_reg  <= '0;
    end else begin
      rvalid_reg <= '0;
      if (t1_valid) begin
        rvalid_reg[t1_owner] <= 1'b1;
        rdata_reg            <= t1_oor ? '0 : mem_rdata;
      end
    end
  end

  assign core_gnt    = gnt_reg[IDX_CORE];
  assign stk_gnt     = gnt_reg[IDX_STK];
  assign dbg_gnt     = gnt_reg[IDX_DBG];
  assign core_rvalid = rvalid_reg[IDX_CORE];
  assign stk_rvalid  = rvalid_reg[IDX_STK];
  assign dbg_rvalid  = rvalid_reg[IDX_DBG];
  assign rdata       = rdata_reg;
  assign err         = err_reg;
  assign mem_en      = mem_en_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed-vector bench for dmem_arbiter with a small
// synchronous RAM model attached to the memory port.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, stk_req, dbg_req;
  logic        core_we, stk_we, dbg_we;
  logic [15:0] core_addr, stk_addr, dbg_addr;
  logic [15:0] core_wdata, stk_wdata, dbg_wdata;
  logic        core_gnt, stk_gnt, dbg_gnt;
  logic        core_rvalid, stk_rvalid, dbg_rvalid;
  logic [15:0] rdata;
  logic        err;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;

  int error_cnt = 0;
  int check_cnt = 0;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(4096)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .stk_req(stk_req), .dbg_req(dbg_req),
    .core_we(core_we), .stk_we(stk_we), .dbg_we(dbg_we),
    .core_addr(core_addr), .stk_addr(stk_addr), .dbg_addr(dbg_addr),
    .core_wdata(core_wdata), .stk_wdata(stk_wdata), .dbg_wdata(dbg_wdata),
    .core_gnt(core_gnt), .stk_gnt(stk_gnt), .dbg_gnt(dbg_gnt),
    .core_rvalid(core_rvalid), .stk_rvalid(stk_rvalid), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model: one-cycle read latency.
  logic [15:0] ram [0:4095];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[11:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[11:0]];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      error_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int who, input logic req, input logic we,
                       input logic [15:0] addr, input logic [15:0] wdata);
    case (who)
      0: begin core_req = req; core_we = we; core_addr = addr; core_wdata = wdata; end
      1: begin stk_req = req; stk_we = we; stk_addr = addr; stk_wdata = wdata; end
      default: begin dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; end
    endcase
  endtask

  function automatic logic [2:0] gnts();
    return {dbg_gnt, stk_gnt, core_gnt};
  endfunction

  function automatic logic [2:0] rvs();
    return {dbg_rvalid, stk_rvalid, core_rvalid};
  endfunction

  logic [15:0] cont_addr [0:2];
  logic [15:0] cont_data [0:2];

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 16'h0000;
    ram[16'h0010] = 16'hBEEF;
    ram[16'h0100] = 16'h1111;
    ram[16'h0200] = 16'h2222;
    ram[16'h0300] = 16'h3333;
    mem_rdata = 16'h0000;
    cont_addr[0] = 16'h0100; cont_addr[1] = 16'h0200; cont_addr[2] = 16'h0300;
    cont_data[0] = 16'h1111; cont_data[1] = 16'h2222; cont_data[2] = 16'h3333;

    rst = 1'b1;
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) @(negedge clk);
    check_val("rst_gnt", 32'(gnts()), 32'h0);
    check_val("rst_rvalid", 32'(rvs()), 32'h0);
    check_val("rst_err", 32'(err), 32'h0);
    check_val("rst_mem_en", 32'(mem_en), 32'h0);
    check_val("rst_mem_we", 32'(mem_we), 32'h0);
    check_val("rst_rdata", 32'(rdata), 32'h0);
    check_val("rst_mem_addr", 32'(mem_addr), 32'h0);
    check_val("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    rst = 1'b0;

    // Core read after reset
    $display("txn: core read 0x0010");
    drive(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    check_val("rd_gnt", 32'(gnts()), 32'h1);
    check_val("rd_mem_en", 32'(mem_en), 32'h1);
    check_val("rd_mem_we", 32'(mem_we), 32'h0);
    check_val("rd_mem_addr", 32'(mem_addr), 32'h0010);
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    check_val("rd_idle_en", 32'(mem_en), 32'h0);
    check_val("rd_early_rv", 32'(rvs()), 32'h0);
    @(negedge clk);
    check_val("rd_rvalid", 32'(rvs()), 32'h1);
    check_val("rd_rdata", 32'(rdata), 32'hBEEF);
    @(negedge clk);
    check_val("rd_rv_pulse", 32'(rvs()), 32'h0);
    check_val("rd_rdata_hold", 32'(rdata), 32'hBEEF);

    // Three-way contention from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("txn: three-way contention, 6 grants");
    for (int w = 0; w < 3; w++) drive(w, 1'b1, 1'b0, cont_addr[w], 16'h0000);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k <= 6) begin
        check_val($sformatf("cont_gnt%0d", k), 32'(gnts()), 32'(3'b001 << ((k - 1) % 3)));
        check_val($sformatf("cont_addr%0d", k), 32'(mem_addr), 32'(cont_addr[(k - 1) % 3]));
        check_val($sformatf("cont_en%0d", k), 32'(mem_en), 32'h1);
      end
      if (k >= 3) begin
        check_val($sformatf("cont_rv%0d", k), 32'(rvs()), 32'(3'b001 << ((k - 3) % 3)));
        check_val($sformatf("cont_rd%0d", k), 32'(rdata), 32'(cont_data[(k - 3) % 3]));
      end
      if (k == 6) for (int w = 0; w < 3; w++) drive(w, 1'b0, 1'b0, 16'h0000, 16'h0000);
    end

    // Back-to-back stack pushes
    $display("txn: stack pushes 0x0FFF 0x0FFE 0x0FFD");
    drive(1, 1'b1, 1'b1, 16'h0FFF, 16'hA001);
    @(negedge clk);
    check_val("push1_gnt", 32'(gnts()), 32'h2);
    check_val("push1_we", 32'(mem_we), 32'h1);
    check_val("push1_addr", 32'(mem_addr), 32'h0FFF);
    check_val("push1_wdata", 32'(mem_wdata), 32'hA001);
    drive(1, 1'b1, 1'b1, 16'h0FFE, 16'hA002);
    @(negedge clk);
    check_val("push2_we", 32'(mem_we), 32'h1);
    check_val("push2_addr", 32'(mem_addr), 32'h0FFE);
    check_val("push2_wdata", 32'(mem_wdata), 32'hA002);
    drive(1, 1'b1, 1'b1, 16'h0FFD, 16'hA003);
    @(negedge clk);
    check_val("push3_we", 32'(mem_we), 32'h1);
    check_val("push3_addr", 32'(mem_addr), 32'h0FFD);
    check_val("push3_wdata", 32'(mem_wdata), 32'hA003);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val($sformatf("push_no_rv%0d", k), 32'(rvs()), 32'h0);
    end

    // Out-of-range debug read
    $display("txn: dbg read 0x1000 (out of range)");
    drive(2, 1'b1, 1'b0, 16'h1000, 16'h0000);
    @(negedge clk);
    check_val("oor_gnt", 32'(gnts()), 32'h4);
    check_val("oor_err", 32'(err), 32'h1);
    check_val("oor_mem_en", 32'(mem_en), 32'h0);
    drive(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    check_val("oor_err_pulse", 32'(err), 32'h0);
    @(negedge clk);
    check_val("oor_rvalid", 32'(rvs()), 32'h4);
    check_val("oor_rdata", 32'(rdata), 32'h0);

    // Overlapping reads, also reading back two pushed words
    $display("txn: core read 0x0FFE then stk read 0x0FFF");
    drive(0, 1'b1, 1'b0, 16'h0FFE, 16'h0000);
    @(negedge clk);
    check_val("ovl_core_gnt", 32'(gnts()), 32'h1);
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1, 1'b1, 1'b0, 16'h0FFF, 16'h0000);
    @(negedge clk);
    check_val("ovl_stk_gnt", 32'(gnts()), 32'h2);
    check_val("ovl_rv_none", 32'(rvs()), 32'h0);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    check_val("ovl_core_rv", 32'(rvs()), 32'h1);
    check_val("ovl_core_rd", 32'(rdata), 32'hA002);
    @(negedge clk);
    check_val("ovl_stk_rv", 32'(rvs()), 32'h2);
    check_val("ovl_stk_rd", 32'(rdata), 32'hA001);

    // Reset while a core read is in flight
    $display("txn: core read 0x0010 then reset mid-read");
    drive(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    check_val("mr_gnt", 32'(gnts()), 32'h1);
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("mr_rst_rdata", 32'(rdata), 32'h0);
    check_val("mr_rst_addr", 32'(mem_addr), 32'h0);
    check_val("mr_rst_en", 32'(mem_en), 32'h0);
    check_val("mr_rst_gnt", 32'(gnts()), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val($sformatf("mr_no_rv%0d", k), 32'(rvs()), 32'h0);
    end
    $display("txn: all three request after reset");
    for (int w = 0; w < 3; w++) drive(w, 1'b1, 1'b1, cont_addr[w], 16'h5555);
    @(negedge clk);
    check_val("mr_first_gnt", 32'(gnts()), 32'h1);
    check_val("mr_first_addr", 32'(mem_addr), 32'h0100);
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", error_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Single-port data-memory arbiter for the 16-bit core.
- Shares one synchronous RAM port between three requesters: core load/store (from the control unit's data-address/write path), the hardware stack unit (push/pop), and the debug/loader port.
- Round-robin, one access per cycle, fully registered memory command.
- Fixed read latency; out-of-range accesses are blocked and flagged.

Parameters:
- ADDR_W, 16, address width of every requester and the RAM.
- DATA_W, 16, data width.
- MEM_DEPTH, 4096, number of implemented words; addresses >= MEM_DEPTH are out of range.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- core_req, stk_req, dbg_req  input  1 each  access request; hold stable until the matching gnt.
- core_we, stk_we, dbg_we  input  1 each  1=write, 0=read.
- core_addr, stk_addr, dbg_addr  input  ADDR_W each  word address.
- core_wdata, stk_wdata, dbg_wdata  input  DATA_W each  write data.
- core_gnt, stk_gnt, dbg_gnt  output  1 each  one-cycle pulse: request accepted.
- core_rvalid, stk_rvalid, dbg_rvalid  output  1 each  one-cycle pulse: read data valid on rdata.
- rdata  output  DATA_W  shared registered read data.
- err  output  1  one-cycle pulse, coincident with the gnt of an out-of-range access.
- mem_en  output  1  RAM enable.
- mem_we  output  1  RAM write enable.
- mem_addr  output  ADDR_W  RAM address.
- mem_wdata  output  DATA_W  RAM write data.
- mem_rdata  input  DATA_W  RAM read data; valid the cycle after a mem_en read.

Behaviour:
- Reset (asynchronous):
  - All gnt, rvalid, err, mem_en and mem_we are 0.
  - rdata, mem_addr and mem_wdata are 0.
  - In-flight reads are discarded; no rvalid is issued for them after reset releases.
  - The round-robin pointer is set to "last granted = dbg", so the first priority order is core > stk > dbg.
- Arbitration, every posedge (edge E1):
  - Sample the req lines and select one requester.
  - Priority starts at the requester after the last granted one, cyclic order core -> stk -> dbg -> core.
  - The pointer updates only when a grant is issued.
- Issue, cycle after E1:
  - The selected requester's gnt is 1.
  - mem_en=1; mem_we, mem_addr and mem_wdata are registered copies of that requester's inputs.
  - All other gnt are 0. With no request, mem_en=0 and no gnt.
- Request protocol:
  - A requester changes req/we/addr/wdata only during its gnt cycle.
  - req still high at the next edge counts as a new access, giving back-to-back throughput of one access per cycle when uncontested.
  - Holding req high while not granted must not lose or duplicate the access.
- Read return:
  - A read issued in cycle C has mem_rdata valid in C+1.
  - At the edge ending C+1, rdata <= mem_rdata and the owner's rvalid is set for cycle C+2.
  - Latency is req sampled (E1) -> gnt 1 cycle; gnt -> rvalid 2 cycles.
  - A 2-entry owner tag pipeline tracks which requester gets each rvalid.
  - Writes produce no rvalid.
- Out of range (addr >= MEM_DEPTH):
  - gnt is still pulsed and err pulses in the same cycle.
  - mem_en stays 0, so the RAM is untouched.
  - A read still returns rvalid 2 cycles later, with rdata=0.
  - The pointer advances as for a normal grant.
- Fairness:
  - With all three requesting continuously, grants rotate core, stk, dbg, core, ...
  - Any waiting requester is granted within 3 cycles of its req being sampled.
- Simultaneous events:
  - A new grant and an earlier read's rvalid may coincide, for the same or different requesters. Both must occur.
  - At most one rvalid is high per cycle.
- rdata holds its last value when no rvalid is asserted.

Test Plan:
- Reset then core read: core_req=1, addr=0x0010 at E1 -> core_gnt and mem_en=1, mem_we=0, mem_addr=0x0010 next cycle. With the RAM returning 0xBEEF, core_rvalid=1 and rdata=0xBEEF two cycles after gnt.
- Three-way contention: all req held high with distinct addrs for 6 cycles -> gnt order core, stk, dbg, core, stk, dbg. mem_addr matches the granted requester each cycle, with no gaps.
- Back-to-back stack pushes: stk_we=1, addrs 0x0FFF, 0x0FFE, 0x0FFD on consecutive cycles, no contention -> three consecutive mem_we pulses with the matching addr/wdata, and no stk_rvalid.
- Out-of-range: dbg read at addr 0x1000 (MEM_DEPTH=4096) -> dbg_gnt and err high in the same cycle, mem_en=0. dbg_rvalid follows 2 cycles later with rdata=0.
- Overlap: core read granted in cycle C, stk read granted in C+1 -> core_rvalid in C+2 and stk_rvalid in C+3, each with the correct data, never simultaneous.
- Reset mid-read: assert rst in the cycle after a core read gnt -> all outputs are 0 immediately. After release, no core_rvalid appears, and the first grant goes to core when all three request.
